// File: rtl/busca_sar_10bit.sv
// Successive-approximation search controller: drives comparator operand b with trial
// values MSB-first and rebuilds the unknown operand a from the menor answers.
module busca_sar_10bit #(
    parameter int LARGURA = 10,
    parameter int ESPERA  = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               iniciar,
    input  logic               cancelar,
    input  logic               menor,
    output logic [LARGURA-1:0] palpite,
    output logic               ocupado,
    output logic               valido,
    output logic [LARGURA-1:0] resultado
);

    typedef enum logic [1:0] {
        OCIOSO,
        TESTE,
        ESPERA_CMP
    } estado_t;

    estado_t            estado, estado_n;
    logic [LARGURA-1:0] acum, acum_n;
    logic [LARGURA-1:0] resultado_n;
    logic [LARGURA-1:0] mascara;
    logic [3:0]         idx, idx_n;
    logic [3:0]         cnt, cnt_n;
    logic               valido_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado    <= OCIOSO;
            acum      <= '0;
            idx       <= '0;
            cnt       <= '0;
            resultado <= '0;
            valido    <= 1'b0;
        end else begin
            estado    <= estado_n;
            acum      <= acum_n;
            idx       <= idx_n;
            cnt       <= cnt_n;
            resultado <= resultado_n;
            valido    <= valido_n;
        end
    end

    // The trial value is the bits already decided plus the bit currently under test.
    always_comb begin
        estado_n    = estado;
        acum_n      = acum;
        idx_n       = idx;
        cnt_n       = cnt;
        resultado_n = resultado;
        valido_n    = 1'b0;
        mascara     = LARGURA'(1) << idx;
        palpite     = '0;
        ocupado     = 1'b0;

        if (estado != OCIOSO) begin
            palpite = acum | mascara;
            ocupado = 1'b1;
        end

        if (cancelar) begin
            estado_n = OCIOSO;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (iniciar) begin
                        acum_n = '0;
                        idx_n  = 4'(LARGURA - 1);
                        if (ESPERA > 0) begin
                            estado_n = ESPERA_CMP;
                            cnt_n    = 4'(ESPERA);
                        end else begin
                            estado_n = TESTE;
                        end
                    end
                end
                ESPERA_CMP: begin
                    cnt_n = cnt - 4'd1;
                    if (cnt <= 4'd1) begin
                        estado_n = TESTE;
                    end
                end
                TESTE: begin
                    if (!menor) begin
                        acum_n = acum | mascara;
                    end
                    if (idx != 4'd0) begin
                        idx_n = idx - 4'd1;
                        if (ESPERA > 0) begin
                            estado_n = ESPERA_CMP;
                            cnt_n    = 4'(ESPERA);
                        end
                    end else begin
                        resultado_n = acum_n;
                        valido_n    = 1'b1;
                        estado_n    = OCIOSO;
                    end
                end
                default: estado_n = OCIOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_busca_sar_10bit.sv
// Bench for busca_sar_10bit: one instance with no comparator wait, one with two wait
// cycles, each checked every cycle against a search-level reference model.
module tb_busca_sar_10bit;

    localparam int L    = 10;
    localparam int ESP1 = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       iniciar   [2];
    logic       cancelar  [2];
    logic       menor     [2];
    logic       ocupado   [2];
    logic       valido    [2];
    logic [9:0] palpite   [2];
    logic [9:0] resultado [2];
    logic [9:0] aval      [2];
    logic       glitchEn  [2];
    logic       glitchNow [2];

    // Reference model state: search in progress, bit step, cycle within the bit.
    logic       mBusy   [2];
    int         mK      [2];
    int         mSub    [2];
    logic [9:0] mVal    [2];
    logic [9:0] mRes    [2];
    logic       mValido [2];

    int nVec = 0;
    int nErr = 0;

    always #5 clk = ~clk;

    busca_sar_10bit u0 (
        .clk(clk), .rst_n(rst_n), .iniciar(iniciar[0]), .cancelar(cancelar[0]),
        .menor(menor[0]), .palpite(palpite[0]), .ocupado(ocupado[0]),
        .valido(valido[0]), .resultado(resultado[0])
    );

    busca_sar_10bit #(.ESPERA(ESP1)) u2 (
        .clk(clk), .rst_n(rst_n), .iniciar(iniciar[1]), .cancelar(cancelar[1]),
        .menor(menor[1]), .palpite(palpite[1]), .ocupado(ocupado[1]),
        .valido(valido[1]), .resultado(resultado[1])
    );

    // Ideal comparator, optionally inverted during cycles where the answer must be ignored.
    assign menor[0] = (aval[0] < palpite[0]) ^ glitchNow[0];
    assign menor[1] = (aval[1] < palpite[1]) ^ glitchNow[1];

    function automatic int esp(input int i);
        return (i == 0) ? 0 : ESP1;
    endfunction

    // Trial at step k: the value's bits above the tested bit, plus the tested bit set.
    function automatic logic [9:0] trial(input logic [9:0] v, input int k);
        int b;
        logic [9:0] hi;
        b  = L - 1 - k;
        hi = (v >> (b + 1)) << (b + 1);
        return hi | (10'd1 << b);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                mBusy[i]   <= 1'b0;
                mK[i]      <= 0;
                mSub[i]    <= 0;
                mVal[i]    <= '0;
                mRes[i]    <= '0;
                mValido[i] <= 1'b0;
            end else begin
                mValido[i] <= 1'b0;
                if (cancelar[i]) begin
                    mBusy[i] <= 1'b0;
                end else if (!mBusy[i]) begin
                    if (iniciar[i]) begin
                        mBusy[i] <= 1'b1;
                        mK[i]    <= 0;
                        mSub[i]  <= 0;
                        mVal[i]  <= aval[i];
                    end
                end else if (mSub[i] < esp(i)) begin
                    mSub[i] <= mSub[i] + 1;
                end else begin
                    mSub[i] <= 0;
                    if (mK[i] == L - 1) begin
                        mBusy[i]   <= 1'b0;
                        mRes[i]    <= mVal[i];
                        mValido[i] <= 1'b1;
                    end else begin
                        mK[i] <= mK[i] + 1;
                    end
                end
            end
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        nVec++;
        if (act != exp) begin
            nErr++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input int i);
        logic [9:0] expPal;
        expPal = mBusy[i] ? trial(mVal[i], mK[i]) : 10'd0;
        cmp($sformatf("palpite%0d", i), palpite[i], expPal);
        cmp($sformatf("ocupado%0d", i), ocupado[i], mBusy[i]);
        cmp($sformatf("valido%0d", i), valido[i], mValido[i]);
        cmp($sformatf("resultado%0d", i), resultado[i], mRes[i]);
    endtask

    task automatic tick;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            glitchNow[i] = glitchEn[i] && mBusy[i] && (mSub[i] < esp(i));
            checkOutput(i);
        end
    endtask

    task automatic applyStimulus(input int i, input logic [9:0] v);
        aval[i]    = v;
        iniciar[i] = 1'b1;
        tick();
        iniciar[i] = 1'b0;
    endtask

    task automatic runSearch(input int i, input logic [9:0] v, input logic [9:0] expRes,
                             input int expLat);
        int n;
        applyStimulus(i, v);
        n = 1;
        while (!valido[i] && n < 200) begin
            tick();
            n++;
        end
        cmp($sformatf("latencia%0d", i), n - 1, expLat);
        cmp($sformatf("res_lit%0d", i), resultado[i], expRes);
    endtask

    logic [9:0] seq155 [10];
    int         pulses;
    int         n;

    initial begin
        seq155 = '{10'h200, 10'h100, 10'h180, 10'h140, 10'h160,
                   10'h150, 10'h158, 10'h154, 10'h156, 10'h155};
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            iniciar[i]   = 1'b0;
            cancelar[i]  = 1'b0;
            aval[i]      = '0;
            glitchEn[i]  = 1'b0;
            glitchNow[i] = 1'b0;
        end
        tick();
        tick();
        cmp("rst_palpite", palpite[0], 0);
        cmp("rst_ocupado", ocupado[0], 0);
        cmp("rst_resultado", resultado[1], 0);
        rst_n = 1'b1;
        tick();

        // Literal trial sequence for 0x155.
        applyStimulus(0, 10'h155);
        cmp("seq_0", palpite[0], seq155[0]);
        for (int k = 1; k < 10; k++) begin
            tick();
            cmp($sformatf("seq_%0d", k), palpite[0], seq155[k]);
        end
        tick();
        cmp("seq_valido", valido[0], 1);
        cmp("seq_res", resultado[0], 10'h155);
        tick();

        runSearch(0, 10'h000, 10'h000, 10);
        tick();
        runSearch(0, 10'h3FF, 10'h3FF, 10);
        tick();

        glitchEn[1] = 1'b1;
        runSearch(1, 10'h2A7, 10'h2A7, 30);
        glitchEn[1] = 1'b0;
        tick();

        // Second start during a search is ignored.
        applyStimulus(0, 10'h155);
        tick(); tick(); tick();
        iniciar[0] = 1'b1;
        tick();
        iniciar[0] = 1'b0;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (valido[0]) pulses++;
        end
        cmp("retrig_pulsos", pulses, 1);
        cmp("retrig_res", resultado[0], 10'h155);

        // Abort mid-search keeps the previous result.
        applyStimulus(0, 10'h2A7);
        tick(); tick(); tick(); tick();
        cancelar[0] = 1'b1;
        tick();
        cancelar[0] = 1'b0;
        cmp("cancel_ocupado", ocupado[0], 0);
        cmp("cancel_palpite", palpite[0], 0);
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (valido[0]) pulses++;
        end
        cmp("cancel_pulsos", pulses, 0);
        cmp("cancel_res", resultado[0], 10'h155);

        // Asynchronous reset mid-search.
        applyStimulus(0, 10'h3FF);
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        cmp("arst_palpite", palpite[0], 0);
        cmp("arst_ocupado", ocupado[0], 0);
        cmp("arst_valido", valido[0], 0);
        cmp("arst_resultado", resultado[0], 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Back-to-back searches.
        applyStimulus(0, 10'h3FF);
        n = 1;
        while (!valido[0] && n < 200) begin
            tick();
            n++;
        end
        cmp("b2b_lat1", n - 1, 10);
        cmp("b2b_res1", resultado[0], 10'h3FF);
        aval[0]    = 10'h001;
        iniciar[0] = 1'b1;
        tick();
        iniciar[0] = 1'b0;
        n = 1;
        while (!valido[0] && n < 200) begin
            tick();
            n++;
        end
        cmp("b2b_gap", n, 11);
        cmp("b2b_res2", resultado[0], 10'h001);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule

// File: doc/busca_sar_10bit.md
# busca_sar_10bit

Successive-approximation search controller that drives the `b` operand of the combinational 10-bit less-than comparator (`menor = a < b`) and consumes its `menor` result. Given an unknown value on the comparator's `a` input, it binary-searches from MSB to LSB, one bit per step, and reports the recovered value. It is the initiator side of the comparator: it generates the trial values (`palpite`) and interprets the answers, for threshold, ADC-style and search use in the datapath.

## Interface
- `LARGURA`, default 10, width of the search value and of `palpite`/`resultado`; step count equals `LARGURA`.
- `ESPERA`, default 0, extra wait cycles per bit before `menor` is sampled (range 0..15); covers a registered or pipelined comparator path.

- `clk`  in  1  single clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `iniciar`  in  1  start request; sampled only in `OCIOSO`.
- `cancelar`  in  1  synchronous abort; highest priority after reset.
- `menor`  in  1  comparator answer, 1 when value < `palpite`.
- `palpite`  out  LARGURA  trial value driven to comparator operand `b`.
- `ocupado`  out  1  high while a search is in progress.
- `valido`  out  1  one-cycle pulse when `resultado` updates.
- `resultado`  out  LARGURA  recovered value; holds until next completion.

## Operation
- States: `OCIOSO`, `TESTE`, `ESPERA_CMP` (used only when `ESPERA>0`).
- Registers: accumulator `acum`, bit index `idx` (4 bits), wait counter `cnt` (4 bits).
- `OCIOSO`: `palpite`=0, `ocupado`=0. When `iniciar`=1, load `acum`=0 and `idx`=LARGURA-1, then go to `TESTE` (or `ESPERA_CMP` with `cnt`=ESPERA when `ESPERA>0`).
- In `TESTE`/`ESPERA_CMP`: `palpite` = `acum` | (1 << `idx`). `ocupado`=1.
- `ESPERA_CMP`: decrement `cnt`; when `cnt` reaches 1, go to `TESTE`. `menor` is ignored in this state.
- `TESTE`: sample `menor`.
  - `menor`=0: set bit `idx` of `acum`.
  - `menor`=1: bit `idx` of `acum` stays 0.
- After the `TESTE` sample:
  - `idx`>0: decrement `idx`, then go to `ESPERA_CMP` or `TESTE`.
  - `idx`=0: load `resultado` with the final `acum`, assert `valido` for the next cycle, go to `OCIOSO`.
- `iniciar` while `ocupado`=1 is ignored; requests are not queued.
- `cancelar`=1 in any state: go to `OCIOSO`. `valido` is not asserted and `resultado` is unchanged. `cancelar` and `iniciar` together in `OCIOSO`: `cancelar` wins and no search starts.
- Width rule: the shift uses `idx` in the range 0..LARGURA-1 only. There is no carry or overflow, and `acum` never exceeds 2^LARGURA-1.

## Timing
- Reset (async assert, sync deassert by the system): state=`OCIOSO`, `palpite`=0, `ocupado`=0, `valido`=0, `resultado`=0, `acum`=0, `idx`=0, `cnt`=0.
- Reset mid-search aborts immediately. No `valido` is produced.
- `iniciar` sampled at edge E0: `ocupado`=1 and the first `palpite` (MSB set) appear after E0.
- Per bit: 1+ESPERA cycles. `menor` is sampled on the last edge of each bit period.
- Latency from E0 to the edge that loads `resultado`: LARGURA×(1+ESPERA) edges. With defaults, edges E1..E10.
- `valido` is high for exactly the cycle after the final sample. `ocupado` falls on the same edge that `valido` rises.
- `iniciar` high during the `valido` cycle is accepted, giving back-to-back searches with no idle gap beyond that cycle.
- `menor` must be stable for the sampling edge. With the combinational comparator and `ESPERA`=0, the result is valid in the same cycle as `palpite`.

## Test plan
- Value 0x155, defaults, `iniciar` pulse -> `palpite` sequence 0x200,0x100,0x180,0x140,0x160,0x150,0x158,0x154,0x156,0x155 on consecutive cycles; `valido` pulse 10 cycles after start with `resultado`=0x155.
- Value 0 -> every `menor`=1, `resultado`=0x000. Value 1023 -> every `menor`=0, `resultado`=0x3FF. Each completes in 10 cycles.
- `ESPERA`=2, value 0x2A7 -> each `palpite` held 3 cycles; `resultado`=0x2A7 after 30 cycles. `menor` glitches driven during the wait cycles have no effect.
- Start with value 0x155, then assert `iniciar` again at step 4 -> ignored; single `valido`; `resultado`=0x155.
- `cancelar` at step 5 -> `ocupado`=0 and `palpite`=0 on the next cycle; no `valido`; `resultado` keeps its previous value. Separately, drop `rst_n` at step 3 -> all outputs 0 asynchronously.
- Back-to-back: `iniciar` held during the `valido` cycle, values 0x3FF then 0x001 -> two `valido` pulses 11 cycles apart with `resultado` 0x3FF then 0x001.
